binarize_threshold_ctrl: RTL and testbench

Controls the threshold used by the camera binarizer. Holds a CPU-written shadow threshold and commits it only at frame boundaries, so no frame is binarized with mixed thresholds. Can optionally run an auto mode that nudges the threshold each frame from a per-frame white-pixel count. Sits in the systemClock domain between the custom-instruction bus and the binarizer threshold input.

---
 rtl/binarize_threshold_ctrl.sv | 163 ++++++++++++++++
 tb/tb_binarize_threshold_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binarize_threshold_ctrl.sv
// Binarizer threshold controller: CPU-written shadow threshold committed on vsync frame
// boundaries, with an optional auto mode nudging the threshold from per-frame white counts.
module binarize_threshold_ctrl #(
    parameter logic [7:0]  CUSTOM_INSTRUCTION_ID = 8'd0,
    parameter logic [7:0]  DEFAULT_THRESHOLD     = 8'd10,
    parameter logic [7:0]  AUTO_STEP             = 8'd1,
    parameter logic [15:0] MIN_FRAME_GAP         = 16'd1024
) (
    input  logic        systemClock,
    input  logic        reset,
    input  logic        vsync,
    input  logic [31:0] whiteCount,
    input  logic        whiteCountValid,
    output logic [7:0]  threshold,
    output logic        thresholdUpdated,
    output logic [15:0] frameCount,
    input  logic        ciStart,
    input  logic        ciCke,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic [31:0] ciResult,
    output logic        ciDone
);

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        HOLD
    } stateType;

    stateType    state;
    logic        vsyncMeta;
    logic        vsyncSync;
    logic        vsyncPrev;
    logic        boundary;
    logic [7:0]  shadow;
    logic        pending;
    logic        autoEn;
    logic        countSeen;
    logic [31:0] lastCount;
    logic [31:0] targetLow;
    logic [31:0] targetHigh;
    logic [15:0] gapCount;
    logic        isMyCi;
    logic [2:0]  ciCmd;
    logic [8:0]  sumUp;
    logic [8:0] diffDown;
    logic [7:0]  nextThreshold;
    logic        unusedCiBits;

    assign isMyCi       = ciStart & ciCke & (ciN == CUSTOM_INSTRUCTION_ID);
    assign ciDone       = isMyCi;
    assign ciCmd        = ciValueA[2:0];
    assign unusedCiBits = ^ciValueA[31:3];

    // vsync is asynchronous: idle-high synchronizer, then a registered falling-edge pulse
    always_ff @(posedge systemClock) begin
        if (reset) begin
            vsyncMeta <= 1'b1;
            vsyncSync <= 1'b1;
            vsyncPrev <= 1'b1;
            boundary  <= 1'b0;
        end else begin
            vsyncMeta <= vsync;
            vsyncSync <= vsyncMeta;
            vsyncPrev <= vsyncSync;
            boundary  <= vsyncPrev & ~vsyncSync;
        end
    end

    // Threshold to apply at the next commit; a pending manual write beats auto mode
    always_comb begin
        sumUp         = {1'b0, threshold} + {1'b0, AUTO_STEP};
        diffDown      = {1'b0, threshold} - {1'b0, AUTO_STEP};
        nextThreshold = threshold;
        if (pending) begin
            nextThreshold = shadow;
        end else if (autoEn && countSeen) begin
            if (lastCount > targetHigh) begin
                nextThreshold = sumUp[8] ? 8'hFF : sumUp[7:0];
            end else if (lastCount < targetLow) begin
                nextThreshold = diffDown[8] ? 8'h00 : diffDown[7:0];
            end
        end
    end

    always_comb begin
        ciResult = 32'd0;
        if (isMyCi) begin
            case (ciCmd)
                3'd0:    ciResult = {24'd0, threshold};
                3'd2:    ciResult = {29'd0, countSeen, pending, autoEn};
                3'd6:    ciResult = {16'd0, frameCount};
                default: ciResult = 32'd0;
            endcase
        end
    end

    // Commit FSM; count captures and CI writes come last so they win over the commit cycle
    always_ff @(posedge systemClock) begin
        if (reset) begin
            state            <= IDLE;
            threshold        <= DEFAULT_THRESHOLD;
            shadow           <= DEFAULT_THRESHOLD;
            thresholdUpdated <= 1'b0;
            frameCount       <= 16'd0;
            pending          <= 1'b0;
            autoEn           <= 1'b0;
            countSeen        <= 1'b0;
            lastCount        <= 32'd0;
            targetLow        <= 32'd0;
            targetHigh       <= 32'hFFFF_FFFF;
            gapCount         <= 16'd0;
        end else begin
            thresholdUpdated <= 1'b0;
            case (state)
                IDLE: begin
                    if (boundary) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    frameCount       <= frameCount + 16'd1;
                    threshold        <= nextThreshold;
                    thresholdUpdated <= (nextThreshold != threshold);
                    pending          <= 1'b0;
                    countSeen        <= 1'b0;
                    gapCount         <= MIN_FRAME_GAP;
                    state            <= HOLD;
                end
                HOLD: begin
                    if (gapCount <= 16'd1) begin
                        state <= IDLE;
                    end
                    if (gapCount != 16'd0) begin
                        gapCount <= gapCount - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (whiteCountValid) begin
                lastCount <= whiteCount;
                countSeen <= 1'b1;
            end

            if (isMyCi) begin
                case (ciCmd)
                    3'd1: begin
                        shadow  <= ciValueB[7:0];
                        pending <= 1'b1;
                    end
                    3'd3:    autoEn     <= ciValueB[0];
                    3'd4:    targetLow  <= ciValueB;
                    3'd5:    targetHigh <= ciValueB;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_binarize_threshold_ctrl.sv
// Bench for binarize_threshold_ctrl: directed frame scenarios then random traffic,
// checked every cycle against an event-level model of commits and CI accesses.
module tb_binarize_threshold_ctrl;

    localparam logic [7:0] ID   = 8'd0;
    localparam int         DEF  = 10;
    localparam int         STEP = 1;
    localparam int         GAP  = 1024;

    logic        systemClock;
    logic        reset;
    logic        vsync;
    logic [31:0] whiteCount;
    logic        whiteCountValid;
    logic [7:0]  threshold;
    logic        thresholdUpdated;
    logic [15:0] frameCount;
    logic        ciStart;
    logic        ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic [31:0] ciResult;
    logic        ciDone;

    int testCount = 0;
    int failCount = 0;
    int pulseCount = 0;

    // Model state
    int          mThr;
    int          mShadow;
    bit          mPending;
    bit          mAuto;
    bit          mSeen;
    logic [31:0] mLast;
    logic [31:0] mLow;
    logic [31:0] mHigh;
    logic [15:0] mFrame;
    bit          mUpd;
    bit          vsPrev;
    int          cyc = 0;
    int          nextAccept;
    int          commitQ[$];

    binarize_threshold_ctrl #(
        .CUSTOM_INSTRUCTION_ID(ID),
        .DEFAULT_THRESHOLD(8'(DEF)),
        .AUTO_STEP(8'(STEP)),
        .MIN_FRAME_GAP(16'(GAP))
    ) dut (
        .systemClock(systemClock),
        .reset(reset),
        .vsync(vsync),
        .whiteCount(whiteCount),
        .whiteCountValid(whiteCountValid),
        .threshold(threshold),
        .thresholdUpdated(thresholdUpdated),
        .frameCount(frameCount),
        .ciStart(ciStart),
        .ciCke(ciCke),
        .ciN(ciN),
        .ciValueA(ciValueA),
        .ciValueB(ciValueB),
        .ciResult(ciResult),
        .ciDone(ciDone)
    );

    initial systemClock = 1'b0;
    always #5 systemClock = ~systemClock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (time %0t)", name, actual, expected, $time);
        end
    endtask

    function automatic bit modelIsMine();
        return ciStart && ciCke && (ciN == ID);
    endfunction

    function automatic logic [31:0] modelResult();
        if (!modelIsMine()) return 32'd0;
        case (ciValueA[2:0])
            3'd0:    return 32'(mThr);
            3'd2:    return {29'd0, mSeen, mPending, mAuto};
            3'd6:    return {16'd0, mFrame};
            default: return 32'd0;
        endcase
    endfunction

    // A falling vsync sampled at edge k is seen by the controller at k+3 and committed at k+4;
    // after a commit no new boundary is accepted for GAP cycles.
    always @(posedge systemClock) begin
        cyc++;
        if (reset) begin
            mThr = DEF; mShadow = DEF; mPending = 0; mAuto = 0; mSeen = 0;
            mLast = 0; mLow = 0; mHigh = 32'hFFFF_FFFF; mFrame = 0; mUpd = 0;
            vsPrev = 1; nextAccept = 0;
            commitQ.delete();
        end else begin
            int newThr;
            mUpd = 0;
            if (commitQ.size() > 0 && commitQ[0] == cyc) begin
                void'(commitQ.pop_front());
                mFrame = mFrame + 16'd1;
                newThr = mThr;
                if (mPending) begin
                    newThr   = mShadow;
                    mPending = 0;
                end else if (mAuto && mSeen) begin
                    if (mLast > mHigh)     newThr = (mThr + STEP > 255) ? 255 : mThr + STEP;
                    else if (mLast < mLow) newThr = (mThr < STEP) ? 0 : mThr - STEP;
                end
                mUpd  = (newThr != mThr);
                mThr  = newThr;
                mSeen = 0;
            end
            if (whiteCountValid) begin
                mLast = whiteCount;
                mSeen = 1;
            end
            if (modelIsMine()) begin
                case (ciValueA[2:0])
                    3'd1: begin mShadow = int'(ciValueB[7:0]); mPending = 1; end
                    3'd3: mAuto = ciValueB[0];
                    3'd4: mLow  = ciValueB;
                    3'd5: mHigh = ciValueB;
                    default: ;
                endcase
            end
            if (vsPrev && !vsync && (cyc + 3 >= nextAccept)) begin
                commitQ.push_back(cyc + 4);
                nextAccept = cyc + 4 + GAP + 1;
            end
            vsPrev = vsync;
        end
    end

    always @(negedge systemClock) begin
        checkOutput("threshold", 32'(threshold), 32'(mThr));
        checkOutput("thresholdUpdated", 32'(thresholdUpdated), 32'(mUpd));
        checkOutput("frameCount", 32'(frameCount), 32'(mFrame));
        checkOutput("ciDone", 32'(ciDone), 32'(modelIsMine()));
        checkOutput("ciResult", ciResult, modelResult());
        if (thresholdUpdated) pulseCount++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge systemClock);
            #1;
        end
    endtask

    task automatic ciAccess(input logic [2:0] cmd, input logic [31:0] data, input logic [7:0] id,
                            output logic [31:0] res, output logic done);
        ciStart  = 1'b1;
        ciCke    = 1'b1;
        ciN      = id;
        ciValueA = {29'd0, cmd};
        ciValueB = data;
        @(negedge systemClock);
        res  = ciResult;
        done = ciDone;
        @(posedge systemClock);
        #1;
        ciStart  = 1'b0;
        ciCke    = 1'b0;
        ciValueA = 32'd0;
        ciValueB = 32'd0;
    endtask

    task automatic pulseWhite(input logic [31:0] cnt);
        whiteCount      = cnt;
        whiteCountValid = 1'b1;
        tick(1);
        whiteCountValid = 1'b0;
    endtask

    task automatic vsyncFall();
        vsync = 1'b0;
        tick(2);
        vsync = 1'b1;
        tick(1);
    endtask

    task automatic frameCommit();
        vsyncFall();
        tick(6);
    endtask

    task automatic applyStimulus();
        reset           = ($urandom_range(2999) == 0);
        if ($urandom_range(199) == 0) vsync = ~vsync;
        whiteCountValid = ($urandom_range(19) == 0);
        whiteCount      = $urandom_range(4000);
        ciStart         = ($urandom_range(3) == 0);
        ciCke           = ($urandom_range(5) != 0);
        ciN             = ($urandom_range(4) == 0) ? ID + 8'd1 : ID;
        ciValueA        = {$urandom_range(1), 28'd0, 3'($urandom_range(7))};
        case (ciValueA[2:0])
            3'd4:    ciValueB = $urandom_range(1500);
            3'd5:    ciValueB = $urandom_range(3000, 500);
            default: ciValueB = $urandom;
        endcase
        tick(1);
    endtask

    initial begin
        logic [31:0] res;
        logic        done;

        reset = 1'b1; vsync = 1'b1; whiteCount = 32'd0; whiteCountValid = 1'b0;
        ciStart = 1'b0; ciCke = 1'b0; ciN = 8'd0; ciValueA = 32'd0; ciValueB = 32'd0;
        tick(3);
        reset = 1'b0;
        tick(2);

        // Reset value read back and foreign-id access
        ciAccess(3'd0, 32'd0, ID, res, done);
        checkOutput("lit reset read", res, 32'd10);
        checkOutput("lit reset done", 32'(done), 32'd1);
        ciAccess(3'd0, 32'd0, ID + 8'd5, res, done);
        checkOutput("lit foreign result", res, 32'd0);
        checkOutput("lit foreign done", 32'(done), 32'd0);

        // Manual write held in shadow until a boundary
        ciAccess(3'd1, 32'h80, ID, res, done);
        tick(3);
        checkOutput("lit shadow held", 32'(threshold), 32'd10);
        ciAccess(3'd2, 32'd0, ID, res, done);
        checkOutput("lit pending status", res, 32'd2);
        pulseCount = 0;
        vsyncFall();
        tick(2);
        checkOutput("lit commit 0x80", 32'(threshold), 32'h80);
        tick(4);
        checkOutput("lit one pulse", 32'(pulseCount), 32'd1);
        checkOutput("lit frame 1", 32'(frameCount), 32'd1);
        ciAccess(3'd2, 32'd0, ID, res, done);
        checkOutput("lit status clear", res, 32'd0);
        tick(1100);

        // Auto increment, then saturation at 255
        ciAccess(3'd5, 32'd1000, ID, res, done);
        ciAccess(3'd3, 32'd1, ID, res, done);
        pulseWhite(32'd5000);
        frameCommit();
        checkOutput("lit auto up", 32'(threshold), 32'h81);
        tick(1100);
        ciAccess(3'd1, 32'hFF, ID, res, done);
        frameCommit();
        tick(1100);
        pulseWhite(32'd5000);
        pulseCount = 0;
        frameCommit();
        checkOutput("lit saturate 255", 32'(threshold), 32'd255);
        checkOutput("lit no pulse at 255", 32'(pulseCount), 32'd0);
        tick(1100);

        // Auto decrement floored at 0, and no change without a fresh count
        ciAccess(3'd1, 32'h00, ID, res, done);
        ciAccess(3'd4, 32'd100, ID, res, done);
        frameCommit();
        tick(1100);
        pulseWhite(32'd10);
        frameCommit();
        checkOutput("lit floor 0", 32'(threshold), 32'd0);
        tick(1100);
        frameCommit();
        checkOutput("lit no count", 32'(threshold), 32'd0);
        checkOutput("lit frame 7", 32'(frameCount), 32'd7);

        // Boundary inside the hold window is dropped
        tick(90);
        frameCommit();
        checkOutput("lit dropped edge", 32'(frameCount), 32'd7);
        tick(1100);
        frameCommit();
        checkOutput("lit counted edge", 32'(frameCount), 32'd8);
        tick(1100);

        // Manual write beats auto, then reset mid-hold
        ciAccess(3'd1, 32'h40, ID, res, done);
        pulseWhite(32'd5000);
        frameCommit();
        checkOutput("lit manual priority", 32'(threshold), 32'h40);
        tick(20);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        checkOutput("lit reset threshold", 32'(threshold), 32'd10);
        checkOutput("lit reset frames", 32'(frameCount), 32'd0);
        frameCommit();
        checkOutput("lit idle after reset", 32'(frameCount), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 8000; i++) applyStimulus();
        reset = 1'b0; ciStart = 1'b0; whiteCountValid = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
